msg_link_slave_rx: RTL and testbench

//  Far-end receiver of the board-to-board message link. Recovers frames sent as
//  MSG_CLK / MSG_TX_FSX / MSG_TX by the master-side message transmitter.
//  All inputs are sampled in the local clk domain and deserialised MSB-first into

---
 rtl/msg_link_slave_rx_if.sv | 23 ++
 rtl/msg_link_slave_rx.sv | 191 +++++++++++++++++++
 tb/tb_msg_link_slave_rx.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_link_slave_rx_if.sv
// Signal bundle between the message-link pins / receiver and the slave-board command decoder.
// The slave modport is the receiver's view; the master modport is the link driver's view.
interface msg_link_slave_rx_if;
    logic        msg_clk_i;
    logic        msg_fsx_i;
    logic        msg_data_i;
    logic        rx_data_vld_o;
    logic [7:0]  rx_data_o;
    logic        rx_sof_o;
    logic        rx_eof_o;
    logic        rx_err_o;
    logic [15:0] rx_byte_num_o;

    modport slave (
        input  msg_clk_i, msg_fsx_i, msg_data_i,
        output rx_data_vld_o, rx_data_o, rx_sof_o, rx_eof_o, rx_err_o, rx_byte_num_o
    );

    modport master (
        output msg_clk_i, msg_fsx_i, msg_data_i,
        input  rx_data_vld_o, rx_data_o, rx_sof_o, rx_eof_o, rx_err_o, rx_byte_num_o
    );
endinterface

// File: rtl/msg_link_slave_rx.sv
// Far-end message-link receiver: synchronises MSG_CLK/FSX/DATA, deserialises MSB-first bytes
// and reports frame boundaries, byte count and errors. Define MSG_SLV_CRC8_EN to check a trailing CRC-8.
module msg_link_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BYTES   = 1024,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    msg_link_slave_rx_if.slave link
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_RECV,
        S_END
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync_clk;
    logic [SYNC_STAGES-1:0] r_sync_fsx;
    logic [SYNC_STAGES-1:0] r_sync_data;
    logic                   r_clk_d;
    logic                   r_fsx_d;

    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [15:0]      r_byte_cnt;
    logic             r_err;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0]       r_crc;

    logic        r_rx_data_vld;
    logic [7:0]  r_rx_data;
    logic        r_rx_sof;
    logic        r_rx_eof;
    logic        r_rx_err;
    logic [15:0] r_rx_byte_num;

    logic       w_clk;
    logic       w_fsx;
    logic       w_data;
    logic       w_rise;
    logic       w_fsx_rise;
    logic       w_start;
    logic       w_tmo;
    logic       w_shift;
    logic       w_byte_done;
    logic       w_byte_ok;
    logic       w_first;
    logic       w_crc_bad;
    logic [7:0] w_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_clk  <= '0;
            r_sync_data <= '0;
            // fsx chain resets high so WAIT_IDLE only exits once a genuine low has propagated.
            r_sync_fsx  <= '1;
            r_clk_d     <= 1'b0;
            r_fsx_d     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the sync chain.
            r_sync_clk  <= {r_sync_clk[SYNC_STAGES-2:0], link.msg_clk_i};
            r_sync_fsx  <= {r_sync_fsx[SYNC_STAGES-2:0], link.msg_fsx_i};
            r_sync_data <= {r_sync_data[SYNC_STAGES-2:0], link.msg_data_i};
            r_clk_d     <= w_clk;
            r_fsx_d     <= w_fsx;
        end
    end

    assign w_clk      = r_sync_clk[SYNC_STAGES-1];
    assign w_fsx      = r_sync_fsx[SYNC_STAGES-1];
    assign w_data     = r_sync_data[SYNC_STAGES-1];
    assign w_rise     = w_clk & ~r_clk_d;
    assign w_fsx_rise = w_fsx & ~r_fsx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            S_WAIT_IDLE: if (!w_fsx) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (w_fsx_rise) begin
                    w_state_nxt = S_RECV;
                    w_start     = 1'b1;
                end
            end
            S_RECV: begin
                if (!w_fsx) begin
                    w_state_nxt = S_END;
                end else if (!w_rise && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
                    w_state_nxt = S_END;
                    w_tmo       = 1'b1;
                end
            end
            S_END:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    // A rise seen in the same cycle as the fsx fall still completes its bit.
    assign w_shift     = (r_state == S_RECV) && w_rise;
    assign w_byte      = {r_shift[6:0], w_data};
    assign w_byte_done = w_shift && (r_bit_cnt == 3'd7);
    assign w_byte_ok   = w_byte_done && (r_byte_cnt < 16'(MAX_BYTES));
    assign w_first     = w_byte_ok && (r_byte_cnt == 16'd0);

`ifdef MSG_SLV_CRC8_EN
    function automatic logic [7:0] f_crc8(input logic [7:0] v);
        logic [7:0] c;
        c = v;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign w_crc_bad = (r_crc != 8'h00);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
            r_tmo_cnt  <= '0;
            r_crc      <= '0;
        end else begin
            if (w_start) begin
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_err      <= 1'b0;
                r_crc      <= '0;
            end
            if (w_shift) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_ok) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
`ifdef MSG_SLV_CRC8_EN
                r_crc      <= f_crc8(r_crc ^ w_byte);
`endif
            end
            if ((w_byte_done && !w_byte_ok) || w_tmo) r_err <= 1'b1;

            if ((r_state == S_RECV) && !w_rise) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else                                r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data_vld <= 1'b0;
            r_rx_data     <= '0;
            r_rx_sof      <= 1'b0;
            r_rx_eof      <= 1'b0;
            r_rx_err      <= 1'b0;
            r_rx_byte_num <= '0;
        end else begin
            r_rx_data_vld <= w_byte_ok;
            r_rx_sof      <= w_first;
            r_rx_eof      <= (r_state == S_END);
            r_rx_err      <= (r_state == S_END) && (r_err || (r_bit_cnt != 3'd0) || w_crc_bad);
            if (w_byte_ok) r_rx_data <= w_byte;
            if (r_state == S_END) r_rx_byte_num <= r_byte_cnt;
            else if (w_first)     r_rx_byte_num <= '0;
        end
    end

    assign link.rx_data_vld_o = r_rx_data_vld;
    assign link.rx_data_o     = r_rx_data;
    assign link.rx_sof_o      = r_rx_sof;
    assign link.rx_eof_o      = r_rx_eof;
    assign link.rx_err_o      = r_rx_err;
    assign link.rx_byte_num_o = r_rx_byte_num;
endmodule

// File: tb/tb_msg_link_slave_rx.sv
// Scoreboard bench for msg_link_slave_rx: a frame-level model queues expected bytes and
// end-of-frame reports; an independent monitor compares them against the DUT outputs.
module tb_msg_link_slave_rx;
    localparam int MAX_BYTES   = 4;
    localparam int TIMEOUT_CYC = 256;
    localparam int HALF        = 4;

    typedef struct {
        logic [7:0] data;
        logic       sof;
    } byte_exp_t;

    typedef struct {
        int   num;
        logic err;
    } eof_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    msg_link_slave_rx_if link();

    msg_link_slave_rx #(
        .SYNC_STAGES(2),
        .MAX_BYTES  (MAX_BYTES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    int n_checks = 0;
    int n_passed = 0;

    byte_exp_t  exp_bytes[$];
    eof_exp_t   exp_eofs[$];
    logic [7:0] tx_q[$];

    int         m_cnt;
    bit         m_ovf;
    logic [7:0] m_crc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    // CRC-8 as polynomial long division by x^8+x^2+x+1.
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [15:0] v;
        v = {crc ^ b, 8'h00};
        for (int i = 15; i >= 8; i--) if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
        return v[7:0];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit drop_fsx);
        link.msg_data_i = b;
        wait_clk(HALF);
        link.msg_clk_i = 1'b1;
        if (drop_fsx) link.msg_fsx_i = 1'b0;
        wait_clk(HALF);
        link.msg_clk_i = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_cnt < MAX_BYTES) begin
            exp_bytes.push_back('{data: b, sof: (m_cnt == 0)});
            m_crc = crc8_upd(m_crc, b);
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic push_eof(input bit partial, input bit tmo);
        bit crc_bad;
`ifdef MSG_SLV_CRC8_EN
        crc_bad = (m_crc != 8'h00);
`else
        crc_bad = 1'b0;
`endif
        exp_eofs.push_back('{num: m_cnt, err: (m_ovf || partial || tmo || crc_bad)});
    endtask

    // Sends tx_q as one frame, then `extra` trailing bits; optionally drops fsx on the
    // final rise, or stalls MSG_CLK until the receiver times out.
    task automatic send_frame(input int extra, input bit coinc, input bit tmo);
        bit last;
        bit drop;
        bit dropped;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_crc   = 8'h00;
        dropped = 1'b0;
        link.msg_fsx_i = 1'b1;
        wait_clk(HALF);
        foreach (tx_q[i]) begin
            for (int k = 7; k >= 0; k--) begin
                last = (i == tx_q.size() - 1) && (k == 0);
                drop = last && coinc && !tmo && (extra == 0);
                if (k == 0) model_byte(tx_q[i]);
                if (drop) begin
                    push_eof(1'b0, 1'b0);
                    dropped = 1'b1;
                end
                send_bit(tx_q[i][k], drop);
            end
        end
        for (int j = 0; j < extra; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        if (tmo) begin
            push_eof(extra != 0, 1'b1);
            wait_clk(TIMEOUT_CYC + 10);
            link.msg_fsx_i = 1'b0;
        end else if (!dropped) begin
            push_eof(extra != 0, 1'b0);
            link.msg_fsx_i = 1'b0;
        end
        wait_clk(12);
    endtask

    task automatic send_raw_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) send_bit(b[k], 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vld"},      32'(link.rx_data_vld_o), 0);
        check({tag, "_data"},     32'(link.rx_data_o), 0);
        check({tag, "_sof"},      32'(link.rx_sof_o), 0);
        check({tag, "_eof"},      32'(link.rx_eof_o), 0);
        check({tag, "_err"},      32'(link.rx_err_o), 0);
        check({tag, "_byte_num"}, 32'(link.rx_byte_num_o), 0);
    endtask

    byte_exp_t mon_b;
    eof_exp_t  mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (link.rx_data_vld_o) begin
                check("vld_eof_overlap", 32'(link.rx_eof_o), 0);
                if (exp_bytes.size() == 0) begin
                    check("spurious_vld", 32'(link.rx_data_vld_o), 0);
                end else begin
                    mon_b = exp_bytes.pop_front();
                    check("rx_data", 32'(link.rx_data_o), 32'(mon_b.data));
                    check("rx_sof",  32'(link.rx_sof_o), 32'(mon_b.sof));
                end
            end else if (link.rx_sof_o) begin
                check("sof_without_vld", 32'(link.rx_sof_o), 0);
            end
            if (link.rx_eof_o) begin
                if (exp_eofs.size() == 0) begin
                    check("spurious_eof", 32'(link.rx_eof_o), 0);
                end else begin
                    mon_e = exp_eofs.pop_front();
                    check("eof_byte_num", 32'(link.rx_byte_num_o), 32'(mon_e.num));
                    check("eof_err",      32'(link.rx_err_o), 32'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        bit coinc;
        logic [7:0] c;

        link.msg_clk_i  = 1'b0;
        link.msg_fsx_i  = 1'b0;
        link.msg_data_i = 1'b0;
        wait_clk(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_clk(6);
        check_outputs_zero("post_reset");

        tx_q = '{8'hA5, 8'h3C};
        send_frame(0, 1'b0, 1'b0);

        tx_q = '{8'h5A};
        send_frame(3, 1'b0, 1'b0);

        tx_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        send_frame(0, 1'b0, 1'b0);

        tx_q = '{8'hC3};
        send_frame(0, 1'b0, 1'b1);
        tx_q = '{8'h00, 8'h00};
        send_frame(0, 1'b0, 1'b0);

        tx_q = {};
        send_frame(0, 1'b0, 1'b0);

        tx_q = '{8'h81, 8'h7E};
        send_frame(0, 1'b1, 1'b0);

        tx_q = '{8'h01, 8'h07};
        send_frame(0, 1'b0, 1'b0);
        tx_q = '{8'h01, 8'h08};
        send_frame(0, 1'b0, 1'b0);

        // Reset in the middle of byte 3 of 5; the remainder must produce nothing.
        m_cnt = 0;
        m_ovf = 1'b0;
        m_crc = 8'h00;
        link.msg_fsx_i = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < 2; i++) begin
            c = 8'h11 * 8'(i + 1);
            for (int k = 7; k >= 0; k--) begin
                if (k == 0) model_byte(c);
                send_bit(c[k], 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
        wait_clk(8);
        check("drained_before_reset", 32'(exp_bytes.size()), 0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_frame_reset");
        wait_clk(4);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) send_bit(1'b0, 1'b0);
        send_raw_byte(8'h44);
        send_raw_byte(8'h55);
        link.msg_fsx_i = 1'b0;
        wait_clk(12);

        tx_q = '{8'hDE, 8'hAD};
        send_frame(0, 1'b0, 1'b0);

        for (int f = 0; f < 16; f++) begin
            n = $urandom_range(0, 6);
            tx_q = {};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            if ((n <= 3) && ($urandom_range(0, 1) == 1)) begin
                c = 8'h00;
                foreach (tx_q[i]) c = crc8_upd(c, tx_q[i]);
                tx_q.push_back(c);
            end
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            coinc = 1'($urandom_range(0, 1));
            send_frame(extra, coinc, 1'b0);
        end

        for (int w = 0; w < 200 && (exp_bytes.size() != 0 || exp_eofs.size() != 0); w++) wait_clk(1);
        check("pending_bytes", 32'(exp_bytes.size()), 0);
        check("pending_eofs",  32'(exp_eofs.size()), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
